// File: rtl/symbol_packer.sv
// symbol_packer: packs a serial bit stream into 1-4 bit symbols, buffers them and releases one per symbol tick
module symbol_packer #(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mod_sel_in,
  input  logic [DIV_W-1:0]              sym_div,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  output logic [3:0]                    sym_data,
  output logic [1:0]                    mod_sel,
  output logic                          sym_strobe,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  logic [1:0]       mod_sel_q, mod_sel_d;
  logic [2:0]       bcnt_q, bcnt_d, bcnt_nxt, bps;
  logic [3:0]       shreg_q, shreg_d, sh_nxt, mask;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic [3:0]       sym_data_q, sym_data_d;
  logic             sym_strobe_q, sym_strobe_d, underrun_q, underrun_d;
  logic             accept, mode_chg, push, pop, tick, empty;
  assign bit_ready  = level_q < LW'(FIFO_DEPTH);
  assign sym_data   = sym_data_q;
  assign mod_sel    = mod_sel_q;
  assign sym_strobe = sym_strobe_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  always_comb begin
    bps      = {1'b0, mod_sel_q} + 3'd1;
    mask     = {mod_sel_q == 2'd3, mod_sel_q[1], |mod_sel_q, 1'b1};
    accept   = bit_valid && bit_ready;
    mode_chg = mod_sel_in != mod_sel_q;
    sh_nxt   = {shreg_q[2:0], bit_in};
    bcnt_nxt = bcnt_q + 3'd1;
    push     = accept && !mode_chg && bcnt_nxt == bps;
    tick     = cnt_q >= sym_div;
    empty    = level_q == '0;
    pop      = tick && !empty;
    // a mode switch throws away the partial symbol, including any bit accepted alongside it
    mod_sel_d    = mod_sel_in;
    shreg_d      = mode_chg ? '0 : accept ? sh_nxt : shreg_q;
    bcnt_d       = (mode_chg || push) ? '0 : accept ? bcnt_nxt : bcnt_q;
    cnt_d        = tick ? '0 : cnt_q + DIV_W'(1);
    mem_d        = mem_q;
    if (push) mem_d[wr_q] = sh_nxt & mask;
    wr_d         = wr_q + AW'(push);
    rd_d         = rd_q + AW'(pop);
    level_d      = level_q + LW'(push) - LW'(pop);
    sym_data_d   = tick ? (empty ? '0 : mem_q[rd_q]) : sym_data_q;
    sym_strobe_d = pop;
    underrun_d   = tick && empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mod_sel_q    <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      mem_q        <= '{default: '0};
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      sym_data_q   <= '0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mod_sel_q    <= mod_sel_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      level_q      <= level_d;
      sym_data_q   <= sym_data_d;
      sym_strobe_q <= sym_strobe_d;
      underrun_q   <= underrun_d;
    end
endmodule

// File: tb/tb_symbol_packer.sv
// tb_symbol_packer: directed checks of packing, tick cadence, backpressure, mode change and reset
module tb_symbol_packer;
  logic       clk, rst_n;
  logic [1:0] mod_sel_in, mod_sel;
  logic [7:0] sym_div;
  logic       bit_in, bit_valid, bit_ready, sym_strobe, underrun;
  logic [3:0] sym_data;
  logic [2:0] fifo_level;
  int         n_chk, n_err, n_under;
  logic [3:0] got [$];
  logic [19:0] pat;
  symbol_packer #(.DIV_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mod_sel_in(mod_sel_in), .sym_div(sym_div),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_data(sym_data), .mod_sel(mod_sel), .sym_strobe(sym_strobe),
    .underrun(underrun), .fifo_level(fifo_level)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (sym_strobe) got.push_back(sym_data);
    if (underrun) n_under++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset(input logic [1:0] m, input logic [7:0] d);
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; mod_sel_in = m; sym_div = d;
    step(); step();
    rst_n = 1'b1;
    got.delete();
    n_under = 0;
  endtask
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_in = b; bit_valid = 1'b1;
    while (!bit_ready && n < 1000) begin step(); n++; end
    check("send_ready", bit_ready, 1);
    step();
    bit_valid = 1'b0;
  endtask
  task automatic send_nib(input logic [3:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  initial begin
    int idx;
    logic acc, seen;
    n_chk = 0; n_err = 0; n_under = 0;
    // reset and idle cadence
    do_reset(2'd0, 8'd3);
    check("rst_level", fifo_level, 0);
    check("rst_data", sym_data, 0);
    check("rst_modsel", mod_sel, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("idle_underrun", underrun, (k % 4) == 0);
      check("idle_strobe", sym_strobe, 0);
      check("idle_data", sym_data, 0);
    end
    check("idle_ready", bit_ready, 1);
    // sym_div = 0 ticks every cycle
    do_reset(2'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin step(); check("div0_underrun", underrun, 1); end
    // 16QAM packing
    do_reset(2'd3, 8'd7);
    step();
    send_nib(4'hB, 4); send_nib(4'h6, 4);
    idle(12);
    check("qam_count", got.size(), 2);
    check("qam_sym0", got[0], 4'hB);
    check("qam_sym1", got[1], 4'h6);
    check("qam_modsel", mod_sel, 3);
    check("qam_underruns", n_under, 0);
    // BPSK
    do_reset(2'd0, 8'd3);
    step();
    send_bit(1'b1); send_bit(1'b0);
    idle(12);
    check("bpsk_count", got.size(), 2);
    check("bpsk_sym0", got[0], 4'h1);
    check("bpsk_sym1", got[1], 4'h0);
    // QPSK
    do_reset(2'd1, 8'd3);
    step();
    send_nib(4'h3, 2); send_nib(4'h1, 2);
    idle(16);
    check("qpsk_count", got.size(), 2);
    check("qpsk_sym0", got[0], 4'h3);
    check("qpsk_sym1", got[1], 4'h1);
    // backpressure with valid held high
    do_reset(2'd3, 8'd255);
    step();
    pat = 20'hA5C39; idx = 0; seen = 1'b0;
    for (int c = 0; c < 3000 && got.size() < 5; c++) begin
      bit_valid = idx < 20;
      bit_in = idx < 20 ? pat[19-idx] : 1'b0;
      acc = bit_valid && bit_ready;
      if (c == 100) begin
        check("bp_accepted", idx, 16);
        check("bp_level", fifo_level, 4);
        check("bp_ready", bit_ready, 0);
      end
      step();
      if (acc) idx++;
      if (!seen && sym_strobe) begin
        seen = 1'b1;
        check("bp_ready_after_pop", bit_ready, 1);
        check("bp_level_after_pop", fifo_level, 3);
      end
    end
    bit_valid = 1'b0;
    check("bp_total_bits", idx, 20);
    check("bp_count", got.size(), 5);
    check("bp_sym0", got[0], 4'hA);
    check("bp_sym1", got[1], 4'h5);
    check("bp_sym2", got[2], 4'hC);
    check("bp_sym3", got[3], 4'h3);
    check("bp_sym4", got[4], 4'h9);
    // mode change mid-symbol, including a bit dropped on the switch cycle
    do_reset(2'd3, 8'd15);
    step();
    send_nib(4'hD, 4);
    send_bit(1'b1); send_bit(1'b1);
    mod_sel_in = 2'd1;
    step();
    send_nib(4'h2, 2);
    mod_sel_in = 2'd3; bit_in = 1'b1; bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
    send_nib(4'h7, 4);
    idle(60);
    check("mc_count", got.size(), 3);
    check("mc_sym0", got[0], 4'hD);
    check("mc_sym1", got[1], 4'h2);
    check("mc_sym2", got[2], 4'h7);
    check("mc_modsel", mod_sel, 3);
    // asynchronous reset mid-stream
    do_reset(2'd3, 8'd63);
    step();
    send_nib(4'hA, 4);
    for (int i = 0; i < 200 && got.size() < 1; i++) step();
    check("ar_first", sym_data, 4'hA);
    send_nib(4'h1, 4); send_nib(4'h2, 4); send_nib(4'h3, 4);
    check("ar_level", fifo_level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_level_rst", fifo_level, 0);
    check("ar_data_rst", sym_data, 0);
    check("ar_modsel_rst", mod_sel, 0);
    check("ar_strobe_rst", sym_strobe, 0);
    check("ar_underrun_rst", underrun, 0);
    check("ar_ready_rst", bit_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; got.delete(); n_under = 0;
    idle(63);
    check("ar_no_early_tick", n_under, 0);
    step();
    check("ar_first_underrun", underrun, 1);
    check("ar_no_strobe", got.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
